// File: rtl/led_display_arbiter.sv
// Two-client arbiter for a six-digit LED display: round-robin ownership with a minimum dwell.
// Optional blink gating of the enable masks is compiled in with LED_DISPLAY_ARBITER_BLINK_EN.
module led_display_arbiter #(
  parameter int CLK_RATE_HZ = 50000000,
  parameter int DWELL_MS    = 1000,
  parameter int BLINK_HZ    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [23:0] req0_data,
  input  logic [23:0] req1_data,
  input  logic [5:0]  req0_digit_mask,
  input  logic [5:0]  req1_digit_mask,
  input  logic [5:0]  req0_dp_mask,
  input  logic [5:0]  req1_dp_mask,
`ifdef LED_DISPLAY_ARBITER_BLINK_EN
  input  logic [1:0]  req_blink,
`endif
  output logic [1:0]  grant,
  output logic [23:0] data,
  output logic [5:0]  digit_enable_mask,
  output logic [5:0]  decimal_point_enable_mask
);

  localparam int DWELL_CYCLES = CLK_RATE_HZ / 1000 * DWELL_MS;
  localparam int BLINK_HALF   = CLK_RATE_HZ / (2 * BLINK_HZ);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  // State codes double as the grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 1 || BLINK_HALF < 1) begin : g_param_check
    $error("led_display_arbiter: DWELL_CYCLES and BLINK_HALF must be at least 1");
  end

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          last_owner_q, last_owner_d;
  logic [23:0]   data_q, data_d;
  logic [5:0]    digit_q, digit_d;
  logic [5:0]    dp_q, dp_d;

  logic [1:0][23:0] cl_data;
  logic [1:0][5:0]  cl_digit;
  logic [1:0][5:0]  cl_dp;
  logic [1:0][23:0] data_sel;
  logic [1:0][5:0]  digit_sel;
  logic [1:0][5:0]  dp_sel;
  logic [1:0]       blank;

  assign cl_data  = {req1_data, req0_data};
  assign cl_digit = {req1_digit_mask, req0_digit_mask};
  assign cl_dp    = {req1_dp_mask, req0_dp_mask};

`ifdef LED_DISPLAY_ARBITER_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Gate with the phase that will be registered alongside the masks.
  assign blank = req_blink & {2{blink_phase_d}};
`else
  assign blank = 2'b00;
`endif

  // Per-client contribution; at most one is nonzero because state_d is one-hot-or-zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    assign data_sel[gi]  = state_d[gi] ? cl_data[gi] : 24'h0;
    assign digit_sel[gi] = (state_d[gi] && !blank[gi]) ? cl_digit[gi] : 6'h0;
    assign dp_sel[gi]    = (state_d[gi] && !blank[gi]) ? cl_dp[gi] : 6'h0;
  end

  assign data_d  = data_sel[0]  | data_sel[1];
  assign digit_d = digit_sel[0] | digit_sel[1];
  assign dp_d    = dp_sel[0]    | dp_sel[1];

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    dwell_d      = (dwell_q != '0) ? dwell_q - DW'(1) : dwell_q;

    case (state_q)
      IDLE: begin
        if (req == 2'b01)      state_d = OWN0;
        else if (req == 2'b10) state_d = OWN1;
        else if (req == 2'b11) state_d = last_owner_q ? OWN0 : OWN1;
      end
      OWN0: begin
        if (!req[0])                        state_d = req[1] ? OWN1 : IDLE;
        else if (dwell_q == '0 && req[1])   state_d = OWN1;
      end
      OWN1: begin
        if (!req[1])                        state_d = req[0] ? OWN0 : IDLE;
        else if (dwell_q == '0 && req[0])   state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == OWN0) begin
        dwell_d      = DWELL_LOAD;
        last_owner_d = 1'b0;
      end else if (state_d == OWN1) begin
        dwell_d      = DWELL_LOAD;
        last_owner_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      dwell_q      <= '0;
      last_owner_q <= 1'b1;
      data_q       <= '0;
      digit_q      <= '0;
      dp_q         <= '0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
    end
  end

  assign grant                     = state_q;
  assign data                      = data_q;
  assign digit_enable_mask         = digit_q;
  assign decimal_point_enable_mask = dp_q;

endmodule

// File: doc/led_display_arbiter.md
LED_DISPLAY_ARBITER -- requirements
Module: led_display_arbiter

Interface
REQ-001 SHALL have parameter CLK_RATE_HZ, default 50000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter DWELL_MS, default 1000, meaning the minimum ownership time in ms before preemption; DWELL_CYCLES = CLK_RATE_HZ/1000*DWELL_MS, which must be at least 1.
REQ-003 SHALL have parameter BLINK_HZ, default 2, meaning the blink rate; BLINK_HALF = CLK_RATE_HZ/(2*BLINK_HZ), which must be at least 1.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 req  in  2  per-client display request, bit i = client i.
REQ-008 req0_data, req1_data  in  24  six BCD digits per client.
REQ-009 req0_digit_mask, req1_digit_mask  in  6  digit enables per client.
REQ-010 req0_dp_mask, req1_dp_mask  in  6  decimal-point enables per client.
REQ-011 grant  out  2  one-hot-or-zero ownership indication.
REQ-012 data  out  24  digit data to led_display_driver.
REQ-013 digit_enable_mask  out  6  digit enables to led_display_driver.
REQ-014 decimal_point_enable_mask  out  6  decimal-point enables to led_display_driver.

Function
REQ-015 SHALL implement the FSM states IDLE, OWN0 and OWN1; grant equals 2'b00, 2'b01 and 2'b10 respectively.
REQ-016 In IDLE, SHALL grant the single requester; if both request, SHALL grant the client other than last_owner (round-robin pointer, reset value 1, so client 0 wins first).
REQ-017 SHALL assert grant in the cycle after req is first sampled high; all outputs are registered.
REQ-018 On entering OWNi, SHALL load the dwell counter with DWELL_CYCLES-1 and decrement it each cycle to 0, saturating at 0.
REQ-019 In OWNi with req[i] low, SHALL move to OWNj if req[j] is high, else to IDLE, on the next edge regardless of dwell.
REQ-020 In OWNi with req[i] high and dwell at 0, SHALL move to OWNj if req[j] is high, else remain in OWNi.
REQ-021 In OWNi with req[i] high and dwell nonzero, SHALL remain in OWNi.
REQ-022 On every transition into OWNi, SHALL set last_owner to i.
REQ-023 While in OWNi, data and both mask outputs SHALL track client i's inputs with one cycle of latency, sampled live every cycle.
REQ-024 In IDLE, SHALL drive data to 0 and digit_enable_mask and decimal_point_enable_mask to 0 (display blank).
REQ-025 SHALL switch grant and outputs on the same edge; there is no cycle in which the outputs show one client while grant shows another.

Reset
REQ-026 With reset low at a clk edge: state IDLE, grant 0, data 0, both masks 0, dwell 0, last_owner 1, blink phase 0.
REQ-027 A reset asserted mid-ownership SHALL take effect on that edge; a request still high after release is re-granted per REQ-016.

Configuration
REQ-028 Macro LED_DISPLAY_ARBITER_BLINK_EN SHALL control the blink feature.
REQ-029 With LED_DISPLAY_ARBITER_BLINK_EN defined, SHALL add input req_blink[1:0] and a free-running BLINK_HALF counter that toggles the blink phase.
REQ-030 With LED_DISPLAY_ARBITER_BLINK_EN defined, while OWNi, req_blink[i] is high and the phase is 1, SHALL force digit_enable_mask and decimal_point_enable_mask to 0.
REQ-031 With LED_DISPLAY_ARBITER_BLINK_EN undefined, there SHALL be no req_blink port and no blink logic, and outputs follow REQ-023 only.

Verification (CLK_RATE_HZ=10000, DWELL_MS=1 -> DWELL_CYCLES=10, BLINK_HZ=1000 -> BLINK_HALF=5)
REQ-032 Reset release with req=00 -> grant=00, data=0, masks=0 for 20 cycles.
REQ-033 req=01, req0_data=24'h123456, digit mask 6'h3F, dp mask 6'h15 -> grant=01 one cycle later; data=24'h123456, digit_enable_mask=6'h3F, decimal_point_enable_mask=6'h15 on the same edge.
REQ-034 req=11 held from IDLE -> grant=01 for exactly 10 cycles, then grant=10 for 10 cycles, alternating; no cycle in which grant has two bits set.
REQ-035 Owner 0 drops req at dwell cycle 3 with req[1] high -> grant=10 on the next edge; with req[1] low -> grant=00 and digit mask 0.
REQ-036 reset pulsed low for one cycle while grant=10 -> all outputs 0 on that edge; with req=10 still high, grant=10 one cycle after release.
REQ-037 BLINK_EN defined, OWN0, req_blink=01 -> digit_enable_mask alternates 6'h3F and 0 every 5 cycles while data stays 24'h123456.
